// File: rtl/booth_mac_accum_if.sv
// Product-stream and result-FIFO signals of booth_mac_accum.
// master = producer/consumer side, slave = accumulator side.
interface booth_mac_accum_if #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int CNT_WIDTH  = 8
);
   logic                  prod_valid;
   logic [PROD_WIDTH-1:0] product;
   logic [1:0]            prod_sign_mode;
   logic [CNT_WIDTH-1:0]  cfg_len;
   logic                  acc_clr;
   logic [ACC_WIDTH-1:0]  res_data;
   logic                  res_sat;
   logic                  res_valid;
   logic                  res_ready;
   logic                  busy;
   logic                  drop_err;

   modport master (
      output prod_valid, product, prod_sign_mode, cfg_len, acc_clr, res_ready,
      input  res_data, res_sat, res_valid, busy, drop_err
   );

   modport slave (
      input  prod_valid, product, prod_sign_mode, cfg_len, acc_clr, res_ready,
      output res_data, res_sat, res_valid, busy, drop_err
   );
endinterface

// File: rtl/booth_mac_accum.sv
// Frame accumulator for the Booth multiplier product stream with a 2-entry result FIFO.
// Define BOOTH_MAC_SAT_EN for saturating adds and a per-frame sat flag; otherwise sums wrap.
module booth_mac_accum #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int CNT_WIDTH  = 8
) (
   input logic              clk,
   input logic              rst_n,
   booth_mac_accum_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t state, state_next;

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] ext;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] sum;
   logic [CNT_WIDTH-1:0]        cnt;
   logic [CNT_WIDTH-1:0]        cnt_next;
   logic [CNT_WIDTH-1:0]        len;
   logic [CNT_WIDTH-1:0]        len_new;
   logic [CNT_WIDTH-1:0]        len_eff;
   logic                        first;
   logic                        take;
   logic                        done;

   logic [ACC_WIDTH-1:0] mem_data [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic                 pop;
   logic                 full;
   logic                 push_ok;
   logic                 drop;

`ifdef BOOTH_MAC_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic ovf;
   logic frame_sat;
   logic frame_sat_next;
   logic mem_sat [2];

   // Returns {overflow, clamped sum}; one guard bit exposes overflow of the signed add.
   function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic signed [ACC_WIDTH-1:0] b);
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
         return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
      return {1'b0, s[ACC_WIDTH-1:0]};
   endfunction
`endif

   always_comb begin
      ext      = {{(ACC_WIDTH-PROD_WIDTH){bus.product[PROD_WIDTH-1] & (|bus.prod_sign_mode)}},
                  bus.product};
      first    = (state == IDLE);
      base     = first ? '0 : acc;
      len_new  = (bus.cfg_len == '0) ? CNT_WIDTH'(1) : bus.cfg_len;
      len_eff  = first ? len_new : len;
      cnt_next = first ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
      take     = bus.prod_valid && !bus.acc_clr;
      done     = take && (cnt_next == len_eff);
`ifdef BOOTH_MAC_SAT_EN
      {ovf, sum}     = sat_add(base, ext);
      frame_sat_next = (first ? 1'b0 : frame_sat) | ovf;
`else
      sum = base + ext;
`endif
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // FSM: next-state logic; abort wins over a coincident product
   always_comb begin
      state_next = state;
      if (bus.acc_clr)
         state_next = IDLE;
      else if (take)
         state_next = done ? IDLE : ACCUM;
   end

   // FSM: outputs
   always_comb begin
      bus.busy = (state == ACCUM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || bus.acc_clr) begin
         acc <= '0;
         cnt <= '0;
         len <= '0;
`ifdef BOOTH_MAC_SAT_EN
         frame_sat <= 1'b0;
`endif
      end else if (take) begin
         acc <= sum;
         cnt <= cnt_next;
         if (first) len <= len_new;
`ifdef BOOTH_MAC_SAT_EN
         frame_sat <= frame_sat_next;
`endif
      end
   end

   // Result FIFO: a full FIFO still accepts a push when the head pops on the same edge
   always_comb begin
      pop     = (count != 2'd0) && bus.res_ready;
      full    = (count == 2'd2);
      push_ok = done && (!full || pop);
      drop    = done && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_data[i] <= '0;
`ifdef BOOTH_MAC_SAT_EN
            mem_sat[i]  <= 1'b0;
`endif
         end
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
         bus.drop_err <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_data[wr_ptr] <= sum;
`ifdef BOOTH_MAC_SAT_EN
            mem_sat[wr_ptr]  <= frame_sat_next;
`endif
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (drop) bus.drop_err <= 1'b1;
      end
   end

   always_comb begin
      bus.res_valid = (count != 2'd0);
      bus.res_data  = mem_data[rd_ptr];
`ifdef BOOTH_MAC_SAT_EN
      bus.res_sat   = mem_sat[rd_ptr];
`else
      bus.res_sat   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Scoreboard bench for booth_mac_accum: a frame-level reference model predicts FIFO results,
// a negedge monitor compares every popped head and the status outputs.
module tb_booth_mac_accum;

   localparam int  PW       = 16;
   localparam int  AW       = 24;
   localparam int  CW       = 8;
   localparam longint SMAX  = 64'sd8388607;
   localparam longint SMIN  = -64'sd8388608;

   logic clk;
   logic rst_n;

   booth_mac_accum_if #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   booth_mac_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [AW:0] exp_q [$];
   int     occ      = 0;
   bit     mdrop    = 0;
   bit     in_reset = 0;
   bit     started  = 0;
   int     mlen     = 0;
   int     mcnt     = 0;
   longint msum     = 0;
   bit     msat     = 0;

   function automatic longint ext_val(input logic [PW-1:0] p, input logic [1:0] mode);
      longint v;
      v = longint'(p);
      if (mode != 2'b00 && v >= 32768) v = v - 65536;
      return v;
   endfunction

   function automatic longint wrap_acc(input longint v);
      longint r;
      r = v & 64'hFFFFFF;
      if (r >= 64'sd8388608) r = r - 64'sd16777216;
      return r;
   endfunction

   always @(posedge clk) begin
      bit pop;
      bit done;
      longint v;
      if (!rst_n) begin
         started  = 1;
         in_reset = 1;
         occ      = 0;
         mdrop    = 0;
         mlen     = 0;
         exp_q.delete();
      end else begin
         in_reset = 0;
         pop  = (occ > 0) && bus.res_ready;
         done = 0;
         if (bus.acc_clr) begin
            mlen = 0;
         end else if (bus.prod_valid) begin
            if (mlen == 0) begin
               mlen = (bus.cfg_len == 0) ? 1 : int'(bus.cfg_len);
               mcnt = 0;
               msum = 0;
               msat = 0;
            end
            v = msum + ext_val(bus.product, bus.prod_sign_mode);
`ifdef BOOTH_MAC_SAT_EN
            if (v > SMAX) begin v = SMAX; msat = 1; end
            else if (v < SMIN) begin v = SMIN; msat = 1; end
`else
            v = wrap_acc(v);
`endif
            msum = v;
            mcnt++;
            if (mcnt == mlen) begin
               done = 1;
               mlen = 0;
            end
         end
         if (done) begin
            if (occ == 2 && !pop) mdrop = 1;
            else begin
               exp_q.push_back({msat, msum[AW-1:0]});
               occ++;
            end
         end
         if (pop) occ--;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [AW:0] e;
      if (started) begin
         if (in_reset) begin
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_data",  bus.res_data,  0);
            chk("rst_res_sat",   bus.res_sat,   0);
            chk("rst_busy",      bus.busy,      0);
            chk("rst_drop_err",  bus.drop_err,  0);
         end else begin
            chk("res_valid", bus.res_valid, (occ != 0));
            chk("drop_err",  bus.drop_err,  mdrop);
            chk("busy",      bus.busy,      (mlen != 0));
            if (bus.res_valid && bus.res_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_unexpected: got %h expected no result at %0t", bus.res_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_data", bus.res_data, e[AW-1:0]);
                  chk("res_sat",  bus.res_sat,  e[AW]);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit pv, input logic [PW-1:0] p, input logic [1:0] m, input bit clr);
      bus.prod_valid     = pv;
      bus.product        = p;
      bus.prod_sign_mode = m;
      bus.acc_clr        = clr;
      @(posedge clk);
      #2;
      bus.prod_valid = 1'b0;
      bus.acc_clr    = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.prod_valid = 1'b0;
      bus.acc_clr    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.prod_valid     = 1'b0;
      bus.product        = '0;
      bus.prod_sign_mode = 2'b00;
      bus.cfg_len        = 8'd1;
      bus.acc_clr        = 1'b0;
      bus.res_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // unsigned frame of four 0xFE01
      bus.cfg_len = 8'd4;
      for (int i = 0; i < 3; i++) step(1, 16'hFE01, 2'b00, 0);
      chk("t1_busy_mid", bus.busy, 1);
      chk("t1_valid_mid", bus.res_valid, 0);
      step(1, 16'hFE01, 2'b00, 0);
      chk("t1_valid", bus.res_valid, 1);
      chk("t1_data", bus.res_data, 24'h03F804);
      chk("t1_sat", bus.res_sat, 0);
      chk("t1_busy", bus.busy, 0);
      bus.res_ready = 1'b1;
      idle(2);

      // mixed signs with a gap
      bus.res_ready = 1'b0;
      bus.cfg_len   = 8'd2;
      step(1, 16'h4000, 2'b11, 0);
      idle(3);
      step(1, 16'h8080, 2'b10, 0);
      chk("t2_data", bus.res_data, 24'hFFC080);
      bus.res_ready = 1'b1;
      idle(2);

      // overflow over a 200-product frame
      bus.cfg_len = 8'd200;
      for (int i = 0; i < 200; i++) step(1, 16'hFE01, 2'b00, 0);
`ifdef BOOTH_MAC_SAT_EN
      chk("t4_data", bus.res_data, 24'h7FFFFF);
      chk("t4_sat", bus.res_sat, 1);
`else
      chk("t4_data", bus.res_data, 24'hC670C8);
      chk("t4_sat", bus.res_sat, 0);
`endif
      idle(2);

      // push and pop on the same edge with the FIFO full
      bus.res_ready = 1'b0;
      bus.cfg_len   = 8'd1;
      step(1, 16'd5, 2'b00, 0);
      step(1, 16'd6, 2'b00, 0);
      bus.res_ready = 1'b1;
      step(1, 16'd7, 2'b00, 0);
      bus.res_ready = 1'b0;
      chk("t6_data", bus.res_data, 24'd6);
      chk("t6_drop", bus.drop_err, 0);
      bus.res_ready = 1'b1;
      idle(1);
      chk("t6_data2", bus.res_data, 24'd7);
      chk("t6_valid2", bus.res_valid, 1);
      idle(1);
      chk("t6_empty", bus.res_valid, 0);

      // backpressure and drop
      bus.res_ready = 1'b0;
      bus.cfg_len   = 8'd1;
      step(1, 16'd1, 2'b01, 0);
      step(1, 16'd2, 2'b01, 0);
      step(1, 16'd3, 2'b01, 0);
      chk("t3_drop", bus.drop_err, 1);
      chk("t3_head1", bus.res_data, 24'd1);
      bus.res_ready = 1'b1;
      idle(1);
      chk("t3_head2", bus.res_data, 24'd2);
      idle(1);
      chk("t3_empty", bus.res_valid, 0);
      chk("t3_drop_hold", bus.drop_err, 1);

      // abort by acc_clr, then by reset
      bus.cfg_len = 8'd4;
      step(1, 16'h0010, 2'b00, 0);
      step(1, 16'h0010, 2'b00, 0);
      step(1, 16'h0010, 2'b00, 1);
      chk("t5_clr_busy", bus.busy, 0);
      for (int i = 0; i < 4; i++) step(1, 16'h0001, 2'b00, 0);
      chk("t5_data", bus.res_data, 24'h000004);
      idle(2);
      step(1, 16'h0010, 2'b00, 0);
      step(1, 16'h0010, 2'b00, 0);
      rst_n = 1'b0;
      idle(1);
      chk("t5_rst_valid", bus.res_valid, 0);
      chk("t5_rst_data", bus.res_data, 0);
      chk("t5_rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 16'h0001, 2'b00, 0);
      chk("t5_data_rst", bus.res_data, 24'h000004);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.cfg_len   = 8'($urandom_range(0, 5));
         bus.res_ready = 1'($urandom_range(0, 1));
         step($urandom_range(0, 9) < 6, 16'($urandom), 2'($urandom_range(0, 3)),
              $urandom_range(0, 29) == 0);
      end
      bus.res_ready = 1'b1;
      idle(4);
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
